wbp2axilite: RTL and testbench

WBP2AXILITE -- requirements
Module: wbp2axilite

---
 rtl/wbp2axilite.sv | 192 +++++++++++++++++++
 tb/tb_wbp2axilite.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbp2axilite.sv
`default_nettype none
// ============================================================================
// Module   : wbp2axilite
// Brief    : Wishbone pipelined slave to AXI4-lite master bridge. Tracks up
//            to 2^LGFIFO outstanding same-direction requests; bus errors and
//            aborted cycles drain the remaining responses in a FLUSH state.
// Revision : 1.0 - initial release
// ============================================================================
module wbp2axilite #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int LGFIFO           = 4,
    localparam int AW              = C_AXI_ADDR_WIDTH - 2,
    localparam int DW              = C_AXI_DATA_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_axi_reset_n,
    // Wishbone pipelined slave
    input  logic                        i_wb_cyc,
    input  logic                        i_wb_stb,
    input  logic                        i_wb_we,
    input  logic [AW-1:0]               i_wb_addr,
    input  logic [DW-1:0]               i_wb_data,
    input  logic [DW/8-1:0]             i_wb_sel,
    output logic                        o_wb_stall,
    output logic                        o_wb_ack,
    output logic [DW-1:0]               o_wb_data,
    output logic                        o_wb_err,
    // AXI-lite write address
    output logic                        o_axi_awvalid,
    input  logic                        i_axi_awready,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
    output logic [2:0]                  o_axi_awprot,
    // AXI-lite write data
    output logic                        o_axi_wvalid,
    input  logic                        i_axi_wready,
    output logic [DW-1:0]               o_axi_wdata,
    output logic [DW/8-1:0]             o_axi_wstrb,
    // AXI-lite write response
    input  logic                        i_axi_bvalid,
    output logic                        o_axi_bready,
    input  logic [1:0]                  i_axi_bresp,
    // AXI-lite read address
    output logic                        o_axi_arvalid,
    input  logic                        i_axi_arready,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
    output logic [2:0]                  o_axi_arprot,
    // AXI-lite read data
    input  logic                        i_axi_rvalid,
    output logic                        o_axi_rready,
    input  logic [DW-1:0]               i_axi_rdata,
    input  logic [1:0]                  i_axi_rresp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [LGFIFO:0] c_full = {1'b1, {LGFIFO{1'b0}}};
    localparam logic [LGFIFO:0] c_one  = {{LGFIFO{1'b0}}, 1'b1};

    state_t                      r_state;
    logic [LGFIFO:0]             r_count;
    logic                        r_dir;      // 1: outstanding requests are writes
    logic                        r_awvalid;
    logic                        r_wvalid;
    logic                        r_arvalid;
    logic [C_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [DW-1:0]               r_wdata;
    logic [DW/8-1:0]             r_wstrb;
    logic [DW-1:0]               r_rdata;

    logic                        w_accept;
    logic                        w_b_hs;
    logic                        w_r_hs;
    logic                        w_resp;
    logic                        w_resp_err;
    logic                        w_deliver;
    logic [LGFIFO:0]             w_count_next;
    logic                        w_unused;

    // Responses are always accepted while out of reset
    assign o_axi_bready = i_axi_reset_n;
    assign o_axi_rready = i_axi_reset_n;

    assign o_axi_awvalid = r_awvalid;
    assign o_axi_wvalid  = r_wvalid;
    assign o_axi_arvalid = r_arvalid;
    assign o_axi_awaddr  = r_addr;
    assign o_axi_araddr  = r_addr;
    assign o_axi_wdata   = r_wdata;
    assign o_axi_wstrb   = r_wstrb;
    assign o_axi_awprot  = 3'b000;
    assign o_axi_arprot  = 3'b000;
    assign o_wb_data     = r_rdata;

    // One request in flight on the address/data channels at a time; a
    // direction change waits for the pipe to drain so acks stay in order.
    assign o_wb_stall = !i_axi_reset_n
                     || r_awvalid || r_wvalid || r_arvalid
                     || (r_count == c_full)
                     || ((r_count != '0) && (i_wb_we != r_dir))
                     || (r_state == S_FLUSH);

    assign w_accept   = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign w_b_hs     = i_axi_bvalid && o_axi_bready;
    assign w_r_hs     = i_axi_rvalid && o_axi_rready;
    assign w_resp     = w_b_hs || w_r_hs;
    assign w_resp_err = (w_b_hs && i_axi_bresp[1]) || (w_r_hs && i_axi_rresp[1]);
    assign w_deliver  = i_wb_cyc && (r_state != S_FLUSH);

    // Only the error bit of the response codes matters to Wishbone
    assign w_unused = ^{i_axi_bresp[0], i_axi_rresp[0]};

    // Outstanding-transaction count after this cycle's accept/response
    always_comb begin
        w_count_next = r_count;
        case ({w_accept, w_resp})
            2'b10:   w_count_next = r_count + c_one;
            2'b01:   w_count_next = r_count - c_one;
            default: w_count_next = r_count;
        endcase
    end

    // Control FSM: state, outstanding count, direction and WB responses
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_dir    <= 1'b0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            if (w_accept)
                r_dir <= i_wb_we;
            o_wb_ack <= w_resp && !w_resp_err && w_deliver;
            o_wb_err <= w_resp &&  w_resp_err && w_deliver;
            case (r_state)
                S_FLUSH: begin
                    if (w_count_next == '0)
                        r_state <= S_IDLE;
                end
                default: begin
                    if (w_count_next == '0)
                        r_state <= S_IDLE;
                    else if (!i_wb_cyc || (w_resp && w_resp_err))
                        r_state <= S_FLUSH;
                    else
                        r_state <= S_BUSY;
                end
            endcase
        end
    end

    // AXI request channels and read-data capture
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_accept)
                r_addr <= {i_wb_addr, 2'b00};
            if (w_accept && i_wb_we) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_wdata   <= i_wb_data;
                r_wstrb   <= i_wb_sel;
            end else begin
                if (i_axi_awready)
                    r_awvalid <= 1'b0;
                if (i_axi_wready)
                    r_wvalid <= 1'b0;
            end
            if (w_accept && !i_wb_we)
                r_arvalid <= 1'b1;
            else if (i_axi_arready)
                r_arvalid <= 1'b0;
            if (w_r_hs)
                r_rdata <= i_axi_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wbp2axilite.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbp2axilite
// Brief    : Directed testbench for wbp2axilite with a cycle-level reference
//            model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbp2axilite;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int FULL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [AW-1:0] i_wb_addr = '0;
    logic [DW-1:0] i_wb_data = '0;
    logic [3:0]    i_wb_sel = '0;
    logic          o_wb_stall, o_wb_ack, o_wb_err;
    logic [DW-1:0] o_wb_data;
    logic          o_axi_awvalid, o_axi_wvalid, o_axi_arvalid;
    logic          i_axi_awready = 1'b1, i_axi_wready = 1'b1, i_axi_arready = 1'b1;
    logic [27:0]   o_axi_awaddr, o_axi_araddr;
    logic [2:0]    o_axi_awprot, o_axi_arprot;
    logic [DW-1:0] o_axi_wdata;
    logic [3:0]    o_axi_wstrb;
    logic          i_axi_bvalid = 1'b0, i_axi_rvalid = 1'b0;
    logic          o_axi_bready, o_axi_rready;
    logic [1:0]    i_axi_bresp = '0, i_axi_rresp = '0;
    logic [DW-1:0] i_axi_rdata = '0;

    int checks = 0;
    int failures = 0;
    int n_ack = 0;
    int n_err = 0;

    wbp2axilite #(
        .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(28), .LGFIFO(4)
    ) dut (
        .i_clk(clk), .i_axi_reset_n(rst_n),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .o_wb_err(o_wb_err),
        .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awprot(o_axi_awprot),
        .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
        .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
        .i_axi_bresp(i_axi_bresp),
        .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arprot(o_axi_arprot),
        .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (state after the last clock edge) -----
    int          m_cnt;
    bit          m_dir, m_flush, m_aw, m_w, m_ar, m_ack, m_err, m_rd;
    logic [27:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    bit          e_stall, e_acc, e_resp, e_rerr, e_deliver;

    // Compare outputs with the model, then advance the model across the next edge
    always @(negedge clk) begin
        if (o_wb_ack) n_ack++;
        if (o_wb_err) n_err++;
        if (!rst_n) begin
            chk("rst_flags", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_wb_ack,
                              o_wb_err, o_axi_bready, o_axi_rready}, 64'd0);
            chk("rst_data", {o_wb_data, o_axi_wstrb}, 64'd0);
            chk("rst_addr", {o_axi_awaddr, o_axi_araddr}, 64'd0);
            chk("rst_wdata", o_axi_wdata, 64'd0);
            chk("rst_stall", o_wb_stall, 64'd1);
            m_cnt = 0; m_dir = 0; m_flush = 0; m_aw = 0; m_w = 0; m_ar = 0;
            m_ack = 0; m_err = 0; m_rd = 0; m_addr = '0; m_wdata = '0;
            m_rdata = '0; m_wstrb = '0;
        end else begin
            e_stall = m_aw || m_w || m_ar || (m_cnt == FULL)
                   || (m_cnt != 0 && i_wb_we != m_dir) || m_flush;
            chk("stall", o_wb_stall, e_stall);
            chk("awvalid", o_axi_awvalid, m_aw);
            chk("wvalid", o_axi_wvalid, m_w);
            chk("arvalid", o_axi_arvalid, m_ar);
            if (m_aw) chk("awaddr", o_axi_awaddr, m_addr);
            if (m_w)  chk("wpayload", {o_axi_wdata, o_axi_wstrb}, {m_wdata, m_wstrb});
            if (m_ar) chk("araddr", o_axi_araddr, m_addr);
            chk("ack", o_wb_ack, m_ack);
            chk("err", o_wb_err, m_err);
            if (m_ack && m_rd) chk("rdata", o_wb_data, m_rdata);
            chk("readies", {o_axi_bready, o_axi_rready}, 64'd3);
            chk("prot", {o_axi_awprot, o_axi_arprot}, 64'd0);

            e_acc     = i_wb_cyc && i_wb_stb && !e_stall;
            e_resp    = i_axi_bvalid || i_axi_rvalid;
            e_rerr    = (i_axi_bvalid && i_axi_bresp[1]) || (i_axi_rvalid && i_axi_rresp[1]);
            e_deliver = i_wb_cyc && !m_flush;
            m_ack = e_resp && !e_rerr && e_deliver;
            m_err = e_resp && e_rerr && e_deliver;
            m_rd  = i_axi_rvalid;
            if (i_axi_rvalid) m_rdata = i_axi_rdata;
            if (e_resp && m_cnt > 0) m_cnt--;
            if (m_aw && i_axi_awready) m_aw = 0;
            if (m_w && i_axi_wready) m_w = 0;
            if (m_ar && i_axi_arready) m_ar = 0;
            if (e_acc) begin
                m_cnt++;
                m_dir  = i_wb_we;
                m_addr = {i_wb_addr, 2'b00};
                if (i_wb_we) begin
                    m_aw = 1; m_w = 1; m_wdata = i_wb_data; m_wstrb = i_wb_sel;
                end else begin
                    m_ar = 1;
                end
            end
            if (m_cnt == 0) m_flush = 0;
            else if (!i_wb_cyc || (e_resp && e_rerr)) m_flush = 1;
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic cyc1();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = a; i_wb_data = d; i_wb_sel = s;
        #1;
        for (int k = 0; k < 200 && o_wb_stall; k++) begin
            @(posedge clk); #2;
        end
        chk("issue_wait", o_wb_stall, 64'd0);
        @(posedge clk); #1;
        i_wb_stb = 1'b0;
    endtask

    task automatic resp_b(input logic [1:0] r);
        i_axi_bvalid = 1'b1; i_axi_bresp = r;
        cyc1();
        i_axi_bvalid = 1'b0; i_axi_bresp = 2'b00;
    endtask

    task automatic resp_r(input logic [1:0] r, input logic [31:0] d);
        i_axi_rvalid = 1'b1; i_axi_rresp = r; i_axi_rdata = d;
        cyc1();
        i_axi_rvalid = 1'b0; i_axi_rresp = 2'b00;
    endtask

    int a0, e0;

    initial begin
        repeat (3) cyc1();
        rst_n = 1'b1;
        i_wb_cyc = 1'b1;

        // Single write, accepted on the first edge after reset
        issue(1'b1, 26'h10, 32'hDEADBEEF, 4'hF);
        chk("t1_awaddr", o_axi_awaddr, 64'h40);
        chk("t1_valids", {o_axi_awvalid, o_axi_wvalid}, 64'd3);
        chk("t1_wdata", o_axi_wdata, 64'hDEADBEEF);
        cyc1();
        chk("t1_valids_done", {o_axi_awvalid, o_axi_wvalid}, 64'd0);
        resp_b(2'b00);
        chk("t1_ack", o_wb_ack, 64'd1);
        cyc1();
        chk("t1_ack_pulse", o_wb_ack, 64'd0);

        // Single read
        issue(1'b0, 26'h3, 32'h0, 4'hF);
        chk("t2_araddr", o_axi_araddr, 64'hC);
        cyc1();
        resp_r(2'b00, 32'h12345678);
        chk("t2_ack", o_wb_ack, 64'd1);
        chk("t2_data", o_wb_data, 64'h12345678);
        cyc1();

        // Write-address backpressure
        i_axi_awready = 1'b0;
        issue(1'b1, 26'h20, 32'hA5A5_0F0F, 4'h3);
        cyc1();
        chk("t3_wvalid_drop", o_axi_wvalid, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_aw_hold", {o_axi_awvalid, o_wb_stall}, 64'd3);
            cyc1();
        end
        i_axi_awready = 1'b1;
        cyc1();
        chk("t3_aw_done", o_axi_awvalid, 64'd0);
        resp_b(2'b00);
        cyc1();

        // Error on the first of three pipelined reads
        a0 = n_ack; e0 = n_err;
        for (int i = 1; i <= 3; i++) issue(1'b0, AW'(i), 32'h0, 4'hF);
        cyc1();
        resp_r(2'b10, 32'hBAD0BAD0);
        chk("t4_err", {o_wb_err, o_wb_ack}, 64'd2);
        chk("t4_flush_stall", o_wb_stall, 64'd1);
        resp_r(2'b00, 32'h1111);
        resp_r(2'b00, 32'h2222);
        chk("t4_released", o_wb_stall, 64'd0);
        cyc1();
        chk("t4_counts", {32'(n_ack - a0), 32'(n_err - e0)}, {32'd0, 32'd1});

        // Fill to 16 outstanding writes, then abort the cycle
        for (int i = 0; i < FULL; i++) issue(1'b1, AW'(i + 8'h40), 32'(i), 4'hF);
        cyc1();
        i_wb_stb = 1'b1; i_wb_we = 1'b1;
        #1;
        chk("t5_full_stall", o_wb_stall, 64'd1);
        cyc1();
        chk("t5_no_accept", o_axi_awvalid, 64'd0);
        i_wb_stb = 1'b0;
        i_wb_cyc = 1'b0;
        a0 = n_ack;
        cyc1();
        for (int i = 0; i < FULL; i++) resp_b(2'b00);
        cyc1();
        cyc1();
        chk("t5_no_ack", 32'(n_ack - a0), 64'd0);
        i_wb_cyc = 1'b1;
        #1;
        chk("t5_idle", o_wb_stall, 64'd0);

        // Direction change waits for the write pipe to drain
        issue(1'b1, 26'h7, 32'h77, 4'hF);
        issue(1'b1, 26'h8, 32'h88, 4'hF);
        cyc1();
        i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 26'h5;
        #1;
        chk("t6_stall2", o_wb_stall, 64'd1);
        resp_b(2'b00);
        chk("t6_stall1", o_wb_stall, 64'd1);
        resp_b(2'b00);
        chk("t6_free", o_wb_stall, 64'd0);
        cyc1();
        i_wb_stb = 1'b0;
        chk("t6_read", {o_axi_arvalid, 4'h0, o_axi_araddr}, {33'd0, 1'b1, 4'h0, 28'h14});
        cyc1();
        resp_r(2'b00, 32'hCAFEF00D);
        chk("t6_rdata", {o_wb_ack, o_wb_data}, {31'd0, 1'b1, 32'hCAFEF00D});
        repeat (3) cyc1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
